uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte FIFO plus drain state machine, directly upstream of the 8N2 RS-232 transmitter.
- Accepts bytes from system logic with a simple write strobe.
- Buffers up to 2**DEPTH_LOG2 bytes.
- Issues one-cycle tx_start pulses with stable tx_data, paced by the transmitter's tx_busy, with an optional inter-byte idle gap.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 16 bytes.
- GAP_CYCLES, 0, extra clk cycles of line idle inserted after each byte completes; 0 disables the gap. Maximum 65535.

Ports:
- clk  in  1  system clock, same clock as the transmitter.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe; one byte per cycle.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  DEPTH_LOG2+1  bytes currently stored, 0..DEPTH.
- overflow  out  1  sticky; a write was dropped.
- clr_overflow  in  1  clears overflow.
- tx_start  out  1  to transmitter TxD_start; registered, one-cycle pulse.
- tx_data  out  8  to transmitter TxD_data; registered, held until the next pop.
- tx_busy  in  1  from transmitter TxD_busy.
- idle  out  1  high when empty=1, FSM is in IDLE and tx_busy=0.

Behaviour:
- Reset values:
  - count=0, empty=1, full=0, overflow=0.
  - tx_start=0, tx_data=8'h00, FSM=IDLE.
  - Read/write pointers = 0.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo DEPTH.
  - full and empty are derived from registered count.
  - Write accepted when wr_en=1 and full=0.
  - wr_en=1 with full=1: byte is dropped and overflow is set next cycle. This holds even if a pop occurs in the same cycle; no write-through when full.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - overflow set and clr_overflow in the same cycle: set wins.
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE, GAP.
  - IDLE: if empty=0 and tx_busy=0, pop the head into tx_data, move read pointer, go to START.
  - START: tx_start=1 for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. The transmitter's busy is registered, so it rises the cycle after tx_start.
  - WAIT_DONE: when tx_busy=0, go to GAP if GAP_CYCLES>0, else IDLE. Load the gap counter with GAP_CYCLES-1.
  - GAP: decrement the 16-bit counter; at 0 go to IDLE.
- Latency:
  - Byte written at cycle N into an empty FIFO with an idle transmitter: empty=0 at N+1, pop at N+1, tx_data valid and tx_start=1 at N+2.
  - Back-to-back bytes with GAP_CYCLES=0: next tx_start 2 cycles after tx_busy falls.
- tx_data changes only on a pop and is stable from START through WAIT_DONE.
- Reset mid-operation:
  - FIFO contents are discarded and the FSM returns to IDLE.
  - The transmitter has no reset, so it may still be busy. The IDLE guard on tx_busy=0 prevents a start until it finishes.
- tx_start is never asserted while tx_busy=1.

Decomposition:
- Package uart_pkg holds:
  - BYTE_W=8.
  - Enum feeder_state_t {IDLE, START, WAIT_ACK, WAIT_DONE, GAP}.
  - GAP_W=16.
- Sub-module byte_fifo (params DEPTH_LOG2, WIDTH):
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty, overflow, clr_overflow.
  - Synchronous read; rd_data registered on rd_en.
- uart_tx_feeder instantiates byte_fifo and holds the FSM and gap counter.

Test Plan:
- Single byte: reset, write 8'hA5 at cycle 10 → tx_start=1 only at cycle 12 with tx_data=8'hA5; empty=1 from cycle 12; with transmitter model at 115200 baud / 12 MHz, TxD shows start bit, LSB-first 10100101, 2 stop bits; idle=1 after busy falls.
- Burst 20 writes of 0x00..0x13, DEPTH=16, transmitter busy → count reaches 16, full=1; bytes 0x10..0x13 dropped if no pop yet; overflow=1; output sequence is in-order and gap-free; overflow clears only on clr_overflow.
- Simultaneous write and pop at count=1 → count stays 1, pointers wrap correctly across index 15→0 over 40 bytes, no corruption.
- GAP_CYCLES=5, two queued bytes → exactly 5 extra cycles between tx_busy falling and the 2-cycle start latency; tx_start never overlaps tx_busy=1.
- Reset asserted mid-byte while tx_busy=1, 3 bytes queued → outputs return to reset values asynchronously; after release, no tx_start until tx_busy=0; the queued bytes are never sent.
- wr_en with full=1 and a pop in the same cycle → byte dropped, overflow=1, count=15 next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit feeder.
//   BYTE_W         : width of one transmitted byte
//   GAP_W          : width of the inter-byte idle gap counter
//   feeder_state_t : states of the drain machine that hands bytes to the
//                    8N2 transmitter
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int GAP_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } feeder_state_t;

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Circular byte buffer with registered occupancy count and a sticky
// overflow flag.
//   clk, rst_n    : clock and asynchronous active-low reset
//   wr_en/wr_data : write strobe and data, one entry per cycle
//   rd_en/rd_data : pop strobe; rd_data is registered and only changes
//                   on an accepted pop
//   count         : entries stored, 0..2**DEPTH_LOG2
//   full/empty    : derived from count
//   overflow      : sticky, set when a write arrives while full
//   clr_overflow  : clears overflow (a simultaneous new drop wins)
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  wrAccept;
    logic                  rdAccept;

    // A full buffer never takes a write, even if a pop frees a slot in the
    // same cycle; that write is counted as dropped instead.
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign wrAccept = wr_en && !full;
    assign rdAccept = rd_en && !empty;

    // Storage array is left unreset; stale contents are never readable
    // because count gates every pop.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the array size. count moves only when
    // exactly one of push/pop happens, so a simultaneous pair leaves it
    // unchanged while both pointers advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdAccept) begin
                rd_data <= mem[rdPtr];
                rdPtr   <= rdPtr + 1'b1;
            end
            case ({wrAccept, rdAccept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte queue plus drain machine sitting directly in front of an 8N2
// transmitter. Bytes written by system logic are buffered and handed to the
// transmitter one at a time, paced by its busy flag, with an optional idle
// gap after each byte.
//   clk, rst_n    : clock (shared with the transmitter), async active-low reset
//   wr_en/wr_data : byte write strobe and data
//   full, empty   : buffer occupancy flags
//   count         : bytes stored, 0..2**DEPTH_LOG2
//   overflow      : sticky dropped-write flag, cleared by clr_overflow
//   tx_start      : registered one-cycle start pulse to the transmitter
//   tx_data       : registered byte, held from the pop until the next pop
//   tx_busy       : transmitter busy, rises the cycle after tx_start
//   idle          : nothing queued, drain machine idle, transmitter idle
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [BYTE_W-1:0]    wr_data,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG2:0]  count,
    output logic                 overflow,
    input  logic                 clr_overflow,
    output logic                 tx_start,
    output logic [BYTE_W-1:0]    tx_data,
    input  logic                 tx_busy,
    output logic                 idle
);

    // Counter reload covers the first gap cycle, so the machine spends
    // exactly GAP_CYCLES cycles in GAP.
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    feeder_state_t    state;
    feeder_state_t    stateNext;
    logic             popReq;
    logic             startNext;
    logic [GAP_W-1:0] gapCount;
    logic [GAP_W-1:0] gapCountNext;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (BYTE_W)
    ) fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (popReq),
        .rd_data      (tx_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // State, gap counter and the start pulse are all registered. tx_start
    // is loaded on the same edge that enters START, so it is high exactly
    // while the machine sits in START and the freshly popped byte is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gapCount <= '0;
            tx_start <= 1'b0;
        end else begin
            state    <= stateNext;
            gapCount <= gapCountNext;
            tx_start <= startNext;
        end
    end

    // Drain sequencing. The IDLE guard on tx_busy also covers a reset
    // released while the unreset transmitter is still shifting out a byte.
    // WAIT_ACK absorbs the one-cycle lag of the transmitter's busy register.
    always_comb begin
        stateNext    = state;
        popReq       = 1'b0;
        startNext    = 1'b0;
        gapCountNext = gapCount;
        unique case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    popReq    = 1'b1;
                    startNext = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                stateNext = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        stateNext    = GAP;
                        gapCountNext = GAP_LOAD;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            GAP: begin
                if (gapCount == '0) begin
                    stateNext = IDLE;
                end else begin
                    gapCountNext = gapCount - 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign idle = empty && (state == IDLE) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
// Two feeders (no gap and a 5-cycle gap) share one write stream, each
// driving its own behavioural transmitter. A per-cycle monitor keeps an
// unbounded ring-buffer model of every queue and checks occupancy, data
// order, start timing and the transmitter handshake.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DEPTH    = 16;
    localparam int BUSY_LEN = 12;
    localparam int GAP1     = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0;
    logic clr_overflow = 1'b0;
    logic holdBusy = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] overflow;
    logic [1:0] txStart;
    logic [1:0] idle;
    logic [1:0] txBusy;
    logic [1:0] xmitBusy = 2'b00;
    logic [1:0][4:0] count;
    logic [1:0][7:0] txData;
    int xmitCnt [2] = '{0, 0};

    int cyc = 0;
    int testsRun = 0;
    int failCount = 0;

    // reference model state
    logic [7:0] mq [2][256];
    int head [2] = '{0, 0};
    int tail [2] = '{0, 0};
    logic [1:0] modelOvf = 2'b00;
    logic [1:0] inFlight = 2'b00;
    logic [1:0] expecting = 2'b00;
    logic [1:0] prevBusy = 2'b00;
    logic [1:0] prevStart = 2'b00;
    int expectCyc [2] = '{0, 0};
    logic [7:0] lastByte [2];
    logic prevWr = 1'b0;
    logic prevClr = 1'b0;
    logic [7:0] prevData = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign txBusy = xmitBusy | {2{holdBusy}};

    uart_tx_feeder #(.DEPTH_LOG2(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full[0]), .empty(empty[0]), .count(count[0]),
        .overflow(overflow[0]), .clr_overflow(clr_overflow),
        .tx_start(txStart[0]), .tx_data(txData[0]), .tx_busy(txBusy[0]),
        .idle(idle[0])
    );

    uart_tx_feeder #(.DEPTH_LOG2(4), .GAP_CYCLES(GAP1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full[1]), .empty(empty[1]), .count(count[1]),
        .overflow(overflow[1]), .clr_overflow(clr_overflow),
        .tx_start(txStart[1]), .tx_data(txData[1]), .tx_busy(txBusy[1]),
        .idle(idle[1])
    );

    // Transmitter stand-in: registered busy that rises the cycle after a
    // start and stays up for one frame. It has no reset, like the real one.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (xmitBusy[k]) begin
                if (xmitCnt[k] == 1) xmitBusy[k] <= 1'b0;
                xmitCnt[k] <= xmitCnt[k] - 1;
            end else if (txStart[k]) begin
                xmitBusy[k] <= 1'b1;
                xmitCnt[k]  <= BUSY_LEN;
            end
        end
    end

    function automatic string tagK(input string s, input int k);
        return $sformatf("%s[%0d]", s, k);
    endfunction

    function automatic int gapOf(input int k);
        return (k == 0) ? 0 : GAP1;
    endfunction

    task automatic checkOutput(input string tag, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] d, input logic clr);
        wr_en = we;
        wr_data = d;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitQuiet();
        int n = 0;
        while (!(idle == 2'b11) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) checkOutput("quietTimeout", n, 0);
        idleCycles(2);
    endtask

    // Per-cycle monitor: retire the previous cycle into the model (a pop is
    // revealed by the start pulse that follows it), then compare.
    initial begin
        int mc;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    head[k] = 0;
                    tail[k] = 0;
                    modelOvf[k] = 1'b0;
                    inFlight[k] = 1'b0;
                    expecting[k] = 1'b0;
                    checkOutput(tagK("rstCount", k), count[k], 0);
                    checkOutput(tagK("rstStart", k), txStart[k], 0);
                    checkOutput(tagK("rstData", k), txData[k], 0);
                    checkOutput(tagK("rstOvf", k), overflow[k], 0);
                end else begin
                    mc = tail[k] - head[k];
                    if (txStart[k]) begin
                        checkOutput(tagK("startNotBusy", k), txBusy[k], 0);
                        checkOutput(tagK("startWidth", k), prevStart[k], 0);
                        checkOutput(tagK("popNonEmpty", k), (mc > 0) ? 1 : 0, 1);
                        if (mc > 0) begin
                            checkOutput(tagK("txData", k), txData[k], mq[k][head[k] % 256]);
                            head[k]++;
                        end
                        lastByte[k] = txData[k];
                        inFlight[k] = 1'b1;
                    end
                    if (prevWr && mc < DEPTH) begin
                        mq[k][tail[k] % 256] = prevData;
                        tail[k]++;
                    end
                    if (prevWr && mc == DEPTH) modelOvf[k] = 1'b1;
                    else if (prevClr) modelOvf[k] = 1'b0;

                    mc = tail[k] - head[k];
                    checkOutput(tagK("count", k), count[k], mc);
                    checkOutput(tagK("empty", k), empty[k], (mc == 0) ? 1 : 0);
                    checkOutput(tagK("full", k), full[k], (mc == DEPTH) ? 1 : 0);
                    checkOutput(tagK("overflow", k), overflow[k], modelOvf[k]);
                    if (txBusy[k] || mc != 0) checkOutput(tagK("idleLow", k), idle[k], 0);
                    if (inFlight[k] && txBusy[k]) checkOutput(tagK("dataHold", k), txData[k], lastByte[k]);

                    if (expecting[k] && (txStart[k] || cyc == expectCyc[k])) begin
                        checkOutput(tagK("startCycle", k), cyc, expectCyc[k]);
                        checkOutput(tagK("startPulse", k), txStart[k], 1);
                        expecting[k] = 1'b0;
                    end
                    if (prevBusy[k] && !txBusy[k] && inFlight[k] && !holdBusy) begin
                        inFlight[k] = 1'b0;
                        if (mc > 0) begin
                            expecting[k] = 1'b1;
                            expectCyc[k] = cyc + 2 + gapOf(k);
                        end
                    end
                end
                prevBusy[k] = txBusy[k];
                prevStart[k] = txStart[k];
            end
            prevWr = rst_n ? wr_en : 1'b0;
            prevClr = rst_n ? clr_overflow : 1'b0;
            prevData = wr_data;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(6);

        // single byte: start pulse two cycles after the write
        n = cyc;
        applyStimulus(1'b1, 8'hA5, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput(tagK("single.emptyN1", k), empty[k], 0);
            checkOutput(tagK("single.startN1", k), txStart[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput(tagK("single.startN2", k), txStart[k], 1);
            checkOutput(tagK("single.dataN2", k), txData[k], 8'hA5);
            checkOutput(tagK("single.emptyN2", k), empty[k], 1);
        end
        $display("[TB] single byte written at cycle %0d", n);
        @(posedge clk);
        #1;
        waitQuiet();
        for (int k = 0; k < 2; k++) checkOutput(tagK("single.idle", k), idle[k], 1);

        // burst of 20 while the transmitter is held busy
        holdBusy = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput(tagK("burst.count", k), count[k], 16);
            checkOutput(tagK("burst.full", k), full[k], 1);
            checkOutput(tagK("burst.ovf", k), overflow[k], 1);
        end
        @(posedge clk);
        #1;
        holdBusy = 1'b0;
        waitQuiet();
        for (int k = 0; k < 2; k++) checkOutput(tagK("burst.ovfSticky", k), overflow[k], 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 2; k++) checkOutput(tagK("burst.ovfClr", k), overflow[k], 0);

        // write while full in the same cycle as a pop
        holdBusy = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        idleCycles(2);
        holdBusy = 1'b0;
        applyStimulus(1'b1, 8'hEE, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checkOutput(tagK("fullPop.count", k), count[k], 15);
            checkOutput(tagK("fullPop.ovf", k), overflow[k], 1);
        end
        waitQuiet();

        // reset in the middle of a byte with three bytes queued
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        idleCycles(4);
        for (int k = 0; k < 2; k++) begin
            checkOutput(tagK("midRst.busy", k), txBusy[k], 1);
            checkOutput(tagK("midRst.count", k), count[k], 3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput(tagK("asyncRst.count", k), count[k], 0);
            checkOutput(tagK("asyncRst.empty", k), empty[k], 1);
            checkOutput(tagK("asyncRst.full", k), full[k], 0);
            checkOutput(tagK("asyncRst.ovf", k), overflow[k], 0);
            checkOutput(tagK("asyncRst.start", k), txStart[k], 0);
            checkOutput(tagK("asyncRst.data", k), txData[k], 0);
        end
        idleCycles(2);
        rst_n = 1'b1;
        waitQuiet();
        for (int k = 0; k < 2; k++) checkOutput(tagK("afterRst.count", k), count[k], 0);

        // random traffic: wraps pointers, overlaps pushes and pops
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(13, 0) == 0)
                applyStimulus(1'b1, 8'($urandom), ($urandom_range(40, 0) == 0));
            else
                applyStimulus(1'b0, 8'h00, ($urandom_range(60, 0) == 0));
        end
        waitQuiet();
        for (int k = 0; k < 2; k++) checkOutput(tagK("random.drained", k), count[k], 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
